// File: rtl/counter4_sync_pkg.sv
// counter4_sync_pkg: shared width default, terminal-value helper and count type
package counter4_sync_pkg;
  localparam int DEFAULT_WIDTH = 4;
  function automatic longint unsigned max_for_width(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
  typedef logic [DEFAULT_WIDTH-1:0] count_t;
endpackage

// File: rtl/counter4_sync_core.sv
// counter4_sync_core: count register with reset/enable mux and wrap detect
module counter4_sync_core #(
  parameter int WIDTH = 4,
  parameter longint unsigned MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             wrap_evt
);
  localparam logic [WIDTH-1:0] M = WIDTH'(MAX_COUNT);
  // >= also pulls any out-of-range value back to zero on the next enabled edge
  always_ff @(posedge clk)
    q <= rst ? '0 : en ? (q >= M ? '0 : q + 1'b1) : q;
  assign wrap_evt = !rst && en && q == M;
endmodule

// File: rtl/counter4_sync.sv
// counter4_sync: modulo up-counter with terminal-count flag and registered wrap pulse
import counter4_sync_pkg::*;
module counter4_sync #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter longint unsigned MAX_COUNT = max_for_width(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Wrap
);
  logic wrap_evt;
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter4_sync: WIDTH must be 1..32");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > max_for_width(WIDTH)) begin : g_bad_max
    $error("counter4_sync: MAX_COUNT must be 1..2**WIDTH-1");
  end
  counter4_sync_core #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) u_core (
    .clk(Clk),
    .rst(Rst),
    .en(En),
    .q(Q),
    .wrap_evt(wrap_evt)
  );
  assign Tc = Q == WIDTH'(MAX_COUNT);
  always_ff @(posedge Clk)
    Wrap <= wrap_evt;
endmodule

// File: tb/tb_counter4_sync.sv
// tb_counter4_sync: directed checks of default and modulo-10 counters
module tb_counter4_sync;
  import counter4_sync_pkg::*;
  logic clk;
  logic rst_a, en_a, tc_a, wrap_a;
  logic rst_b, en_b, tc_b, wrap_b;
  count_t q_a;
  logic [3:0] q_b;
  int total = 0;
  int bad = 0;

  counter4_sync dut_a (
    .Clk(clk), .Rst(rst_a), .En(en_a), .Q(q_a), .Tc(tc_a), .Wrap(wrap_a)
  );
  counter4_sync #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
    .Clk(clk), .Rst(rst_b), .En(en_b), .Q(q_b), .Tc(tc_b), .Wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int q, input bit tc, input bit wr);
    chk({tag, ".q"}, 32'(q_a), q);
    chk({tag, ".tc"}, 32'(tc_a), 32'(tc));
    chk({tag, ".wrap"}, 32'(wrap_a), 32'(wr));
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    step();
    chk_a("reset", 0, 0, 0);
    chk("reset_b.q", 32'(q_b), 0);
    rst_a = 1'b0;
    step();
    chk_a("post_reset", 0, 0, 0);

    en_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_a($sformatf("count%0d", i), i % 16, (i % 16) == 15, i == 16);
    end

    en_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_a($sformatf("hold%0d", i), 4, 0, 0);
    end

    en_a = 1'b1;
    for (int i = 0; i < 11; i++) step();
    chk_a("at_max", 15, 1, 0);
    rst_a = 1'b1;
    step();
    chk_a("rst_prio", 0, 0, 0);
    rst_a = 1'b0; en_a = 1'b0;
    step();
    chk_a("rst_prio_after", 0, 0, 0);

    en_a = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk_a("mid7", 7, 0, 0);
    rst_a = 1'b1;
    step();
    chk_a("mid_rst", 0, 0, 0);
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_a("resume3", 3, 0, 0);

    for (int i = 0; i < 12; i++) step();
    chk_a("to_max", 15, 1, 0);
    step();
    chk_a("wrap_again", 0, 0, 1);
    en_a = 1'b0;
    step();
    chk_a("wrap_clear_hold", 0, 0, 0);

    rst_b = 1'b0; en_b = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("mod10_%0d.q", i), 32'(q_b), i % 10);
      chk($sformatf("mod10_%0d.tc", i), 32'(tc_b), 32'((i % 10) == 9));
      chk($sformatf("mod10_%0d.wrap", i), 32'(wrap_b), 32'(i == 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
